trackletcalculator_div_seq_30s_17ns_16s: RTL and testbench



---
 rtl/tc_div_pkg.sv | 50 +++++
 rtl/tc_div_step.sv | 24 ++
 rtl/trackletcalculator_div_seq_30s_17ns_16s.sv | 152 +++++++++++++++
 tb/tb_trackletcalculator_div_seq_30s_17ns_16s.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tc_div_pkg.sv
// Shared constants, types and output formatting for the tracklet divider.
// TC_DIV_RADIX4_EN selects two quotient bits per CALC cycle.
package tc_div_pkg;

    localparam int DIVIDEND_W = 30;
    localparam int DIVISOR_W  = 17;
    localparam int QUOT_W     = 16;
    localparam int CNT_W      = 5;

`ifdef TC_DIV_RADIX4_EN
    localparam int ITER = 15;
`else
    localparam int ITER = 30;
`endif

    localparam logic [QUOT_W-1:0] QMAX = 16'h7fff;
    localparam logic [QUOT_W-1:0] QMIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef struct packed {
        logic [QUOT_W-1:0]  quot;
        logic [DIVISOR_W:0] rem;
        logic               ovf;
    } res_t;

    // Apply the dividend sign and saturate the magnitude quotient.
    function automatic res_t form_result(
        input logic [DIVIDEND_W-1:0] qm,
        input logic [DIVISOR_W:0]    rm,
        input logic                  neg
    );
        res_t r;
        r.rem = neg ? (~rm + 1'b1) : rm;
        if (neg) begin
            r.ovf  = (qm > 30'd32768);
            r.quot = r.ovf ? QMIN
                           : (~qm[QUOT_W-1:0] + 1'b1);
        end else begin
            r.ovf  = (qm > 30'd32767);
            r.quot = r.ovf ? QMAX : qm[QUOT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/tc_div_step.sv
// One restoring-division step: shift in a dividend bit,
// compare against the divisor and subtract when it fits.
module tc_div_step
    import tc_div_pkg::*;
(
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W:0]   diff;

    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {2'b00, divisor});
        // The true difference is below the divisor, so 18 bits suffice.
        diff    = shifted[DIVISOR_W:0] - {1'b0, divisor};
        rem_out = q_bit ? diff : shifted[DIVISOR_W:0];
    end

endmodule

// File: rtl/trackletcalculator_div_seq_30s_17ns_16s.sv
// Sequential 30s / 17u divider with saturating 16s quotient.
// Define TC_DIV_RADIX4_EN for two quotient bits per cycle.
module trackletcalculator_div_seq_30s_17ns_16s
    import tc_div_pkg::*;
(
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W:0]    remainder,
    output logic                  div_zero,
    output logic                  ovf
);

    state_t                state_q, state_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic                  neg_q, neg_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W:0]    rem_q, rem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [QUOT_W-1:0]     quot_q, quot_d;
    logic [DIVISOR_W:0]    remo_q, remo_d;
    logic                  dz_q, dz_d;
    logic                  ovf_q, ovf_d;

    logic [DIVISOR_W:0]    rem_a;
    logic                  q_a;
    logic [DIVISOR_W:0]    rem_nx;
    logic [DIVIDEND_W-1:0] dvd_nx;
    logic [DIVIDEND_W-1:0] mag;
    res_t                  res;

    tc_div_step u_step0 (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[DIVIDEND_W-1]),
        .divisor (dvs_q),
        .rem_out (rem_a),
        .q_bit   (q_a)
    );

`ifdef TC_DIV_RADIX4_EN
    logic [DIVISOR_W:0] rem_b;
    logic               q_b;

    tc_div_step u_step1 (
        .rem_in  (rem_a),
        .bit_in  (dvd_q[DIVIDEND_W-2]),
        .divisor (dvs_q),
        .rem_out (rem_b),
        .q_bit   (q_b)
    );

    assign rem_nx = rem_b;
    assign dvd_nx = {dvd_q[DIVIDEND_W-3:0], q_a, q_b};
`else
    assign rem_nx = rem_a;
    assign dvd_nx = {dvd_q[DIVIDEND_W-2:0], q_a};
`endif

    // Dividend bits shift out the top while quotient bits fill the bottom.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        neg_d   = neg_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        mag     = dividend[DIVIDEND_W-1]
                ? (~dividend + 1'b1) : dividend;
        res     = form_result(dvd_nx, rem_nx, neg_q);
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d = mag;
                    neg_d = dividend[DIVIDEND_W-1];
                    dvs_d = divisor;
                    rem_d = '0;
                    cnt_d = '0;
                    dz_d  = 1'b0;
                    ovf_d = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        dz_d    = 1'b1;
                        remo_d  = '0;
                        quot_d  = dividend[DIVIDEND_W-1]
                                ? QMIN : QMAX;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                dvd_d = dvd_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = DONE;
                    quot_d  = res.quot;
                    remo_d  = res.rem;
                    ovf_d   = res.ovf;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            neg_q   <= 1'b0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            neg_q   <= neg_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = remo_q;
    assign div_zero  = dz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_trackletcalculator_div_seq_30s_17ns_16s.sv
// Scoreboard bench for the tracklet divider: directed vectors,
// latency, backpressure and mid-operation reset.
module tb_trackletcalculator_div_seq_30s_17ns_16s;

`ifdef TC_DIV_RADIX4_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 31;
`endif

    typedef struct {
        string nm;
        int    q;
        int    r;
        int    dz;
        int    ov;
        int    lat;
    } exp_t;

    exp_t exp_q[$];
    time  acc_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] dividend;
    logic [16:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [17:0] remainder;
    logic        div_zero;
    logic        ovf;

    trackletcalculator_div_seq_30s_17ns_16s dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string nm, input int act,
                       input int expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d",
                     nm, act, expv);
        end
    endtask

    // Monitor: samples on the falling edge, retires on out_ready.
    logic prev_ov = 1'b0;
    time  rise_t  = 0;

    always @(negedge ap_clk) begin
        exp_t e;
        time  a;
        if (!ap_rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) rise_t = $time - 5;
            if (out_valid && !out_ready) begin
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    chk({e.nm, "_hold_q"},
                        int'($signed(quotient)), e.q);
                    chk({e.nm, "_hold_in_ready"},
                        int'(in_ready), 0);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk({e.nm, "_quot"},
                        int'($signed(quotient)), e.q);
                    chk({e.nm, "_rem"},
                        int'($signed(remainder)), e.r);
                    chk({e.nm, "_dz"}, int'(div_zero), e.dz);
                    chk({e.nm, "_ovf"}, int'(ovf), e.ov);
                    chk({e.nm, "_lat"},
                        int'((rise_t - a) / 10) + 1, e.lat);
                end
            end
            prev_ov = out_valid;
        end
    end

    // Driver: called at posedge+1, returns one step after accept.
    task automatic issue(input string nm, input int dvd,
                         input int dvs, input int q, input int r,
                         input int dz, input int ov, input int lat);
        exp_t e;
        int   k;
        e = '{nm, q, r, dz, ov, lat};
        exp_q.push_back(e);
        k = 0;
        while (!in_ready && k < 300) begin
            @(posedge ap_clk);
            #1;
            k++;
        end
        if (!in_ready) begin
            chk({nm, "_accept_timeout"}, 1, 0);
            void'(exp_q.pop_back());
        end else begin
            in_valid = 1'b1;
            dividend = 30'(dvd);
            divisor  = 17'(dvs);
            @(posedge ap_clk);
            acc_q.push_back($time);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(posedge ap_clk);
            #1;
            k++;
        end
        chk("drain_pending", exp_q.size(), 0);
        if (exp_q.size() != 0) begin
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    initial begin
        int k;
        ap_rst_n  = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        #2 ap_rst_n = 1'b0;
        #10;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_quot", int'(quotient), 0);
        chk("rst_rem", int'(remainder), 0);
        chk("rst_dz", int'(div_zero), 0);
        chk("rst_ovf", int'(ovf), 0);
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        issue("pos", 1000, 7, 142, 6, 0, 0, LAT);
        issue("neg", -1000, 7, -142, -6, 0, 0, LAT);
        issue("rtrip", -26214200, 131071, -200, 0, 0, 0, LAT);
        issue("satp", 536870911, 1, 32767, 0, 0, 1, LAT);
        issue("satn", -536870912, 3, -32768, -2, 0, 1, LAT);
        issue("dz_neg", -5, 0, -32768, 0, 1, 0, 1);
        issue("dz_pos", 5, 0, 32767, 0, 1, 0, 1);
        issue("zero", 0, 5, 0, 0, 0, 0, LAT);
        issue("qmax", 65535, 2, 32767, 1, 0, 0, LAT);
        issue("qmax1", 65536, 2, 32767, 0, 0, 1, LAT);
        issue("qmin", -98304, 3, -32768, 0, 0, 0, LAT);
        drain();

        out_ready = 1'b0;
        issue("bp", 12345, 100, 123, 45, 0, 0, LAT);
        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge ap_clk);
            #1;
            k++;
        end
        chk("bp_valid_seen", int'(out_valid), 1);
        repeat (10) @(posedge ap_clk);
        #1 out_ready = 1'b1;
        drain();

        issue("rst", 1000, 7, 142, 6, 0, 0, LAT);
        repeat (11) @(posedge ap_clk);
        #1 ap_rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        issue("post_rst", 100, 9, 11, 1, 0, 0, LAT);
        drain();
        repeat (LAT + 5) @(posedge ap_clk);

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
